// File: rtl/beat_pkg.sv
// Shared constants and FSM encoding for the accelerometer beat scheduler.
package beat_pkg;
    localparam int SAMPLE_W        = 16;
    localparam int DEF_SAMPLE_DIV  = 50000;
    localparam int DEF_ACK_TIMEOUT = 255;
    localparam int DEF_THRESH_HI   = 10000;
    localparam int DEF_THRESH_LO   = 8000;
    localparam int DEF_REFRACT     = 20;
    localparam int DEF_INTERVAL_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_EVAL = 2'd3
    } beat_state_e;
endpackage

// File: rtl/sample_ticker.sv
// Free-running divider: o_tc strobes every DIV enabled cycles, i_clr restarts the count at 0.
// Latency: o_tc is combinational from the registered count; no backpressure.
module sample_ticker #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/beat_scheduler.sv
// Paces accelerometer sample requests and detects beats with hysteresis plus refractory lockout.
// Latency: beat outputs register one cycle after the EVAL cycle; req/ack pacing on input, no output backpressure.
module beat_scheduler
    import beat_pkg::*;
#(
    parameter int SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
    parameter int THRESH_HI       = DEF_THRESH_HI,
    parameter int THRESH_LO       = DEF_THRESH_LO,
    parameter int REFRACT_SAMPLES = DEF_REFRACT,
    parameter int INTERVAL_W      = DEF_INTERVAL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  sample_req,
    input  logic                  sample_ack,
    input  logic [SAMPLE_W-1:0]   sample_data,
    output logic                  beat,
    output logic                  beat_pulse,
    output logic [INTERVAL_W-1:0] beat_interval,
    output logic                  interval_valid,
    output logic                  ack_timeout
);
    localparam int LOCK_W = $clog2(REFRACT_SAMPLES + 2);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic signed [SAMPLE_W-1:0] C_HI = SAMPLE_W'(THRESH_HI);
    localparam logic signed [SAMPLE_W-1:0] C_LO = SAMPLE_W'(THRESH_LO);

    beat_state_e                r_state;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic                       r_armed;
    logic                       r_first;
    logic [LOCK_W-1:0]          r_lock;
    logic [INTERVAL_W-1:0]      r_cnt;
    logic [TO_W-1:0]            r_to_cnt;
    logic                       r_req;
    logic                       r_beat;
    logic                       r_pulse;
    logic [INTERVAL_W-1:0]      r_interval;
    logic                       r_iv;
    logic                       r_to;

    logic                       w_tick_clr;
    logic                       w_tick_en;
    logic                       w_tc;
    logic                       w_fire;
    logic                       w_rearm;
    logic [INTERVAL_W-1:0]      w_cnt_inc;

    assign w_tick_en  = (r_state == ST_WAIT);
    assign w_tick_clr = !w_tick_en;

    sample_ticker #(.DIV(SAMPLE_DIV)) u_ticker (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tick_clr),
        .i_en  (w_tick_en),
        .o_tc  (w_tc)
    );

    // Interval counter saturates so a long silence never wraps into a short interval.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + INTERVAL_W'(1);
    assign w_fire    = r_armed && (r_lock == '0) && (r_sample >= C_HI);
    assign w_rearm   = !r_armed && (r_sample <= C_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sample   <= '0;
            r_armed    <= 1'b1;
            r_first    <= 1'b1;
            r_lock     <= '0;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_req      <= 1'b0;
            r_beat     <= 1'b0;
            r_pulse    <= 1'b0;
            r_interval <= '0;
            r_iv       <= 1'b0;
            r_to       <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            r_iv    <= 1'b0;
            if (!enable) begin
                // Stopping abandons any request in flight; beat and interval keep their last value.
                r_state <= ST_IDLE;
                r_req   <= 1'b0;
                r_armed <= 1'b1;
                r_lock  <= '0;
                r_first <= 1'b1;
                r_cnt   <= '0;
                r_to    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_to    <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_tc) begin
                            r_state  <= ST_REQ;
                            r_req    <= 1'b1;
                            r_to_cnt <= '0;
                        end
                    end
                    ST_REQ: begin
                        if (sample_ack) begin
                            r_sample <= sample_data;
                            r_req    <= 1'b0;
                            r_state  <= ST_EVAL;
                        end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                            r_to    <= 1'b1;
                            r_req   <= 1'b0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    ST_EVAL: begin
                        r_state <= ST_WAIT;
                        if (r_lock != '0) begin
                            r_lock <= r_lock - LOCK_W'(1);
                        end
                        if (w_fire) begin
                            r_beat  <= ~r_beat;
                            r_pulse <= 1'b1;
                            r_armed <= 1'b0;
                            r_lock  <= LOCK_W'(REFRACT_SAMPLES);
                            if (!r_first) begin
                                r_interval <= w_cnt_inc;
                                r_iv       <= 1'b1;
                            end
                            r_cnt   <= '0;
                            r_first <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_rearm) begin
                                r_armed <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sample_req     = r_req;
    assign beat           = r_beat;
    assign beat_pulse     = r_pulse;
    assign beat_interval  = r_interval;
    assign interval_valid = r_iv;
    assign ack_timeout    = r_to;
endmodule

// File: tb/tb_beat_scheduler.sv
// Bench for beat_scheduler: directed scenarios plus randomized traffic against a sample-level beat model.
module tb_beat_scheduler;
    localparam int SAMPLE_DIV  = 4;
    localparam int ACK_TIMEOUT = 3;
    localparam int REFRACT     = 2;
    localparam int THRESH_HI   = 10000;
    localparam int THRESH_LO   = 8000;
    localparam int IW          = 16;
    localparam int CNT_MAX     = (1 << IW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 sample_ack = 1'b0;
    logic signed [15:0]   sample_data = '0;
    logic                 sample_req;
    logic                 beat;
    logic                 beat_pulse;
    logic [IW-1:0]        beat_interval;
    logic                 interval_valid;
    logic                 ack_timeout;

    always #5 clk = ~clk;

    beat_scheduler #(
        .SAMPLE_DIV      (SAMPLE_DIV),
        .ACK_TIMEOUT     (ACK_TIMEOUT),
        .THRESH_HI       (THRESH_HI),
        .THRESH_LO       (THRESH_LO),
        .REFRACT_SAMPLES (REFRACT),
        .INTERVAL_W      (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_req     (sample_req),
        .sample_ack     (sample_ack),
        .sample_data    (sample_data),
        .beat           (beat),
        .beat_pulse     (beat_pulse),
        .beat_interval  (beat_interval),
        .interval_valid (interval_valid),
        .ack_timeout    (ack_timeout)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample-level model state.
    int   m_armed, m_lock, m_cnt, m_first;
    logic ev_pulse = 1'b0, ev_iv = 1'b0;
    int   ev_int = 0;
    logic exp_pulse = 1'b0, exp_iv = 1'b0, exp_beat = 1'b0;
    int   exp_int = 0;
    logic last_acc = 1'b0;
    logic chk_on = 1'b0;
    int   cyc = 0;
    int   obs_pulse = 0, obs_iv = 0, req_run = 0;

    task automatic model_clear();
        m_armed = 1; m_lock = 0; m_cnt = 0; m_first = 1;
    endtask

    task automatic model_sample(input int s);
        int fire;
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        fire  = (m_armed != 0 && m_lock == 0 && s >= THRESH_HI) ? 1 : 0;
        if (m_lock > 0) m_lock--;
        if (fire != 0) begin
            ev_pulse = 1'b1;
            if (m_first == 0) begin
                ev_iv  = 1'b1;
                ev_int = m_cnt;
            end
            m_armed = 0; m_lock = REFRACT; m_cnt = 0; m_first = 0;
        end else if (m_armed == 0 && s <= THRESH_LO) begin
            m_armed = 1;
        end
    endtask

    // mode: 0 = never ack, 1 = ack whenever req is seen high, 2 = ack unconditionally.
    task automatic tick(input logic en_i, input int mode, input logic signed [15:0] d_i);
        logic ack_v;
        @(negedge clk); #1;
        cyc++;
        exp_pulse = ev_pulse;
        exp_iv    = ev_iv;
        if (ev_pulse) exp_beat = ~exp_beat;
        if (ev_iv) exp_int = ev_int;
        ev_pulse = 1'b0;
        ev_iv    = 1'b0;
        ack_v = (mode == 2) || (mode == 1 && sample_req);
        enable      = en_i;
        sample_ack  = ack_v;
        sample_data = d_i;
        last_acc = en_i && ack_v && sample_req;
        if (!en_i) model_clear();
        else if (last_acc) model_sample(int'(d_i));
    endtask

    task automatic send(input logic signed [15:0] d);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1, d);
            if (last_acc) break;
        end
        if (!last_acc) chk("send_accept", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        repeat (3) tick(1'b1, 0, 16'sd0);
    endtask

    task automatic drop_en();
        repeat (2) tick(1'b0, 0, 16'sd0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 0, 16'sd0);
            if (sample_req) break;
        end
        chk("wait_req", 32'(sample_req), 32'd1);
    endtask

    function automatic logic signed [15:0] rnd_data();
        logic signed [15:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'($urandom);
            1: v = 16'(THRESH_HI - 10 + int'($urandom_range(0, 20)));
            2: v = 16'(THRESH_LO - 10 + int'($urandom_range(0, 20)));
            3: v = 16'sd12000;
            4: v = -16'sd20000;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

    // Every-cycle comparison of the beat outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("beat_pulse", 32'(beat_pulse), 32'(exp_pulse));
            chk("interval_valid", 32'(interval_valid), 32'(exp_iv));
            chk("beat", 32'(beat), 32'(exp_beat));
            chk("beat_interval", 32'(beat_interval), 32'(exp_int));
            if (beat_pulse) obs_pulse++;
            if (interval_valid) obs_iv++;
            if (sample_req) begin
                req_run++;
            end else begin
                if (req_run > 0) begin
                    n_chk++;
                    if (req_run > ACK_TIMEOUT) begin
                        n_fail++;
                        $display("FAIL req_hold: sample_req high %0d cycles, limit %0d", req_run, ACK_TIMEOUT);
                    end
                end
                req_run = 0;
            end
        end
    end

    initial begin
        int last_rise, p0, v0, hi, lo, dis_cnt;
        logic req_d;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_sample_req", 32'(sample_req), 32'd0);
        chk("rst_beat", 32'(beat), 32'd0);
        chk("rst_beat_pulse", 32'(beat_pulse), 32'd0);
        chk("rst_interval_valid", 32'(interval_valid), 32'd0);
        chk("rst_beat_interval", 32'(beat_interval), 32'd0);
        chk("rst_ack_timeout", 32'(ack_timeout), 32'd0);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Cadence with immediate ack and zero data.
        last_rise = -1;
        req_d = 1'b0;
        p0 = obs_pulse;
        for (int c = 0; c < 40; c++) begin
            tick(1'b1, 1, 16'sd0);
            if (sample_req && !req_d) begin
                if (last_rise >= 0) chk("cadence_period", 32'(cyc - last_rise), 32'd6);
                last_rise = cyc;
            end
            req_d = sample_req;
        end
        drain();
        chk("cadence_no_beats", 32'(obs_pulse - p0), 32'd0);

        // Hysteresis.
        drop_en();
        p0 = obs_pulse; v0 = obs_iv;
        send(16'sd12000); send(16'sd9000); send(16'sd12000); send(16'sd7000); send(16'sd12000);
        drain();
        chk("hyst_pulses", 32'(obs_pulse - p0), 32'd2);
        chk("hyst_ivalid", 32'(obs_iv - v0), 32'd1);
        chk("hyst_interval", 32'(beat_interval), 32'd4);
        chk("hyst_beat_end", 32'(beat), 32'd0);

        // Refractory lockout.
        drop_en();
        p0 = obs_pulse; v0 = obs_iv;
        send(16'sd12000); send(16'sd5000); send(16'sd12000); send(16'sd12000);
        drain();
        chk("lock_pulses", 32'(obs_pulse - p0), 32'd2);
        chk("lock_ivalid", 32'(obs_iv - v0), 32'd1);
        chk("lock_interval", 32'(beat_interval), 32'd3);

        // Threshold boundaries.
        drop_en();
        p0 = obs_pulse;
        send(16'sd10000); send(-16'sd20000); send(16'sd0); send(16'sd10000);
        drain();
        chk("bnd_hi_exact_neg_rearm", 32'(obs_pulse - p0), 32'd2);
        chk("bnd_interval_a", 32'(beat_interval), 32'd3);
        p0 = obs_pulse;
        send(16'sd8001); send(16'sd8001); send(16'sd12000);
        drain();
        chk("bnd_8001_no_rearm", 32'(obs_pulse - p0), 32'd0);
        send(16'sd8000); send(16'sd12000);
        drain();
        chk("bnd_8000_rearm", 32'(obs_pulse - p0), 32'd1);
        chk("bnd_interval_b", 32'(beat_interval), 32'd5);

        // Ack timeout.
        drop_en();
        chk("to_flag_pre", 32'(ack_timeout), 32'd0);
        wait_req();
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 0, 16'sd0);
            if (sample_req) hi++; else break;
        end
        chk("to_req_high", 32'(hi), 32'd3);
        lo = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 0, 16'sd0);
            if (!sample_req) lo++; else break;
        end
        chk("to_req_gap", 32'(lo), 32'd4);
        chk("to_flag_set", 32'(ack_timeout), 32'd1);
        drop_en();
        chk("to_flag_clear", 32'(ack_timeout), 32'd0);

        // Enable drop in REQ with a late ack, then re-enable.
        wait_req();
        p0 = obs_pulse;
        tick(1'b0, 2, 16'sd12000);
        tick(1'b0, 2, 16'sd12000);
        chk("mid_req_dropped", 32'(sample_req), 32'd0);
        repeat (4) tick(1'b0, 2, 16'sd12000);
        chk("mid_req_stays_low", 32'(sample_req), 32'd0);
        chk("mid_late_ack_ignored", 32'(obs_pulse - p0), 32'd0);
        v0 = obs_iv;
        send(16'sd12000);
        drain();
        chk("mid_first_beat", 32'(obs_pulse - p0), 32'd1);
        chk("mid_first_no_ivalid", 32'(obs_iv - v0), 32'd0);

        // Randomized traffic.
        dis_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (dis_cnt > 0) begin
                dis_cnt--;
                tick(1'b0, ($urandom_range(0, 1) != 0) ? 2 : 0, rnd_data());
            end else if (r < 2 && !last_acc) begin
                dis_cnt = int'($urandom_range(0, 2));
                tick(1'b0, 2, rnd_data());
            end else if (r < 45) begin
                tick(1'b1, 1, rnd_data());
            end else if (r < 55) begin
                tick(1'b1, 2, rnd_data());
            end else begin
                tick(1'b1, 0, rnd_data());
            end
        end
        drain();

        // Asynchronous reset while a request is outstanding.
        drop_en();
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_drop", 32'(sample_req), 32'd0);
        chk("arst_beat", 32'(beat), 32'd0);
        exp_beat = 1'b0; exp_int = 0; exp_pulse = 1'b0; exp_iv = 1'b0;
        ev_pulse = 1'b0; ev_iv = 1'b0;
        model_clear();
        tick(1'b0, 0, 16'sd0);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 0, 16'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
